hdd_multi: RTL and testbench
============================

HDD_MULTI -- requirements
Module: hdd_multi

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 2, number of block units, legal range 1..8.
REQ-002 SHALL have parameter SLOT, default 7, Apple slot number matched in the unit byte.
REQ-003 SHALL have parameter BLK_W, default 16, block-number width, legal range 16..24.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1_000_000, host-request watchdog limit in CLK_14M cycles.
REQ-005 SHALL have port CLK_14M, input, 1, system clock.
REQ-006 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports PHASE_ZERO, IO_SELECT, DEVICE_SELECT and RD, input, 1 each: CPU phase, $Cn00 ROM select, $C0n0 register select, read strobe.
REQ-008 SHALL have ports A (input, 16) and D_IN (input, 8) for the CPU address and write data, and D_OUT (output, 8) for CPU read data.
REQ-009 SHALL have ports mounted and protect, input, NUM_UNITS each, one mounted bit and one write-protect bit per unit.
REQ-010 SHALL have ports blk_rd_req and blk_wr_req (output, 1 each), blk_unit (output, 3) and blk_lba (output, BLK_W) for host block requests.
REQ-011 SHALL have ports blk_ack and blk_err, input, 1 each: host completion pulse and error qualifier.
REQ-012 SHALL have ports ram_addr (input, 9), ram_di (input, 8), ram_we (input, 1) and ram_do (output, 8) for host access to the sector buffer.

Function
REQ-013 An access event SHALL occur on a CLK_14M edge where PHASE_ZERO & DEVICE_SELECT & ~sel_d; sel_d SHALL update only on PHASE_ZERO cycles.
REQ-014 Registers SHALL be: A[3:0]=1 status (read-only, bit7 busy, bit0 error), 2 command, 3 unit, 4/5 memory low/high, 6/7/A block bytes 0/1/2 (byte 2 used only when BLK_W>16), 8 data, 9 error code (read-only).
REQ-015 A read of offset 0 while idle SHALL validate the request, reset the buffer pointer to 0 and return 0x00 on accept, or the error code on reject.
REQ-016 The unit SHALL be valid iff unit[6:4]==SLOT, unit[3:2]==0, index={unit[1:0],unit[7]} < NUM_UNITS, and mounted[index]=1; any other unit SHALL give error 0x28.
REQ-017 Command STATUS SHALL complete immediately with no host request.
REQ-018 WRITE to a protected unit SHALL give error 0x2B; an unknown command SHALL give error 0x01.
REQ-019 The FSM SHALL have states IDLE, RD_REQ and WR_REQ: IDLE->RD_REQ on an accepted READ and IDLE->WR_REQ on an accepted WRITE, both the cycle after the event.
REQ-020 In RD_REQ/WR_REQ the matching request SHALL be held high, with blk_unit and blk_lba stable, until blk_ack; on blk_ack the FSM SHALL return to IDLE.
REQ-021 On blk_ack with blk_err=1 the FSM SHALL set error code 0x27 and status bit0; otherwise it SHALL clear the error.
REQ-022 Busy SHALL equal (state!=IDLE); a read of offset 0 while busy SHALL return 0x80 and start nothing.
REQ-023 Offset-8 reads SHALL return sector_buf[ptr] and offset-8 writes SHALL store D_IN; ptr SHALL post-increment on the falling edge of sel_d and wrap 511->0.
REQ-024 Offset-8 accesses while busy SHALL return 0xFF, SHALL not write the buffer and SHALL not increment ptr.
REQ-025 A write to offset 2 SHALL reset ptr to 0.
REQ-026 IO_SELECT reads with PHASE_ZERO=1 SHALL return firmware ROM[A[7:0]]; D_OUT SHALL be 0xFF in all other cycles.
REQ-027 Host port: ram_do SHALL equal sector_buf[ram_addr] with 1-cycle latency; on a same-address write collision the host write SHALL win.

Reset
REQ-028 Reset SHALL set all registers, ptr, sel_d and error to 0, the FSM to IDLE, blk_rd_req and blk_wr_req to 0, and D_OUT to 0xFF.
REQ-029 Reset mid-request SHALL drop the request on the next edge, and a blk_ack arriving after reset SHALL be ignored.
REQ-030 Sector buffer contents SHALL not be cleared by reset.

Configuration
REQ-031 With HDD_MULTI_TIMEOUT_EN defined, a counter SHALL run in RD_REQ/WR_REQ and, at TIMEOUT_CYC, abort to IDLE with error 0x27.
REQ-032 Without HDD_MULTI_TIMEOUT_EN, there SHALL be no counter, the FSM SHALL wait indefinitely for blk_ack, and TIMEOUT_CYC SHALL be unused.

Structure
REQ-033 Package hdd_multi_pkg SHALL hold the command codes (0..3), the error codes (0x01, 0x27, 0x28, 0x2B), the register offsets and the FSM state enum.
REQ-034 Sub-module hdd_sector_ram SHALL implement the 512x8 dual-port buffer (CPU port and host port).

Verification
REQ-035 Unit 0x70 mounted, READ block 0x0012, exec -> blk_rd_req=1, blk_lba=0x0012, status=0x80 until blk_ack, then status=0x00 and offset 8 streams host data.
REQ-036 Unit 0xF0 with NUM_UNITS=2 and protect[1]=1, WRITE -> D_OUT=0x2B, no blk_wr_req.
REQ-037 Unit 0x71 or 0x60 -> D_OUT=0x28; status read -> 0x01.
REQ-038 513 sequential offset-8 writes -> byte 512 overwrites buffer[0]; host ram_do at address 0 shows it.
REQ-039 blk_ack with blk_err=1 -> error register 0x27, status 0x01; RESET during RD_REQ -> blk_rd_req=0 next cycle.
REQ-040 With HDD_MULTI_TIMEOUT_EN, TIMEOUT_CYC=100 and no blk_ack -> IDLE after 100 cycles with error 0x27.

Source files
------------

// File: rtl/hdd_multi_pkg.sv
// hdd_multi_pkg: shared definitions for the multi-unit block device card.
//   - ProDOS-style command codes and error codes
//   - Register offsets within the $C0n0 device-select window
//   - FSM state enum
//   - rom_byte(): slot firmware ROM contents ($Cn00-$CnFF)
package hdd_multi_pkg;

    localparam logic [7:0] CmdStatus = 8'h00;
    localparam logic [7:0] CmdRead   = 8'h01;
    localparam logic [7:0] CmdWrite  = 8'h02;
    localparam logic [7:0] CmdFormat = 8'h03;

    localparam logic [7:0] ErrNone   = 8'h00;
    localparam logic [7:0] ErrBadCmd = 8'h01;
    localparam logic [7:0] ErrIo     = 8'h27;
    localparam logic [7:0] ErrNoDev  = 8'h28;
    localparam logic [7:0] ErrWrProt = 8'h2B;

    localparam logic [7:0] StatBusy  = 8'h80;

    localparam logic [3:0] RegExec   = 4'h0;
    localparam logic [3:0] RegStatus = 4'h1;
    localparam logic [3:0] RegCmd    = 4'h2;
    localparam logic [3:0] RegUnit   = 4'h3;
    localparam logic [3:0] RegMemLo  = 4'h4;
    localparam logic [3:0] RegMemHi  = 4'h5;
    localparam logic [3:0] RegBlk0   = 4'h6;
    localparam logic [3:0] RegBlk1   = 4'h7;
    localparam logic [3:0] RegData   = 4'h8;
    localparam logic [3:0] RegErr    = 4'h9;
    localparam logic [3:0] RegBlk2   = 4'hA;

    typedef enum logic [1:0] {
        StIdle,
        StRdReq,
        StWrReq
    } state_e;

    // Boot ROM: ProDOS block-device signature at odd offsets 1/3/5/7, device
    // info at $FC-$FF, and an RTS stub at the driver entry point ($0A).
    function automatic logic [7:0] rom_byte(input logic [7:0] addr);
        logic [7:0] b;
        unique case (addr)
            8'h01:   b = 8'h20;
            8'h03:   b = 8'h00;
            8'h05:   b = 8'h03;
            8'h07:   b = 8'h00;
            8'h0A:   b = 8'h60;
            8'hFC:   b = 8'hFF;
            8'hFD:   b = 8'hFF;
            8'hFE:   b = 8'h17;
            8'hFF:   b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/hdd_sector_ram.sv
// hdd_sector_ram: 512x8 sector buffer shared between the CPU and the host.
//   clk_i                    - clock
//   cpu_addr_i/we_i/wdata_i  - CPU port write; cpu_rdata_o is asynchronous read
//   host_addr_i/we_i/wdata_i - host port write; host_rdata_o has 1-cycle latency
// A same-cycle write to the same address from both ports keeps the host data.
module hdd_sector_ram (
    input  logic       clk_i,
    input  logic [8:0] cpu_addr_i,
    input  logic       cpu_we_i,
    input  logic [7:0] cpu_wdata_i,
    output logic [7:0] cpu_rdata_o,
    input  logic [8:0] host_addr_i,
    input  logic       host_we_i,
    input  logic [7:0] host_wdata_i,
    output logic [7:0] host_rdata_o
);

    logic [7:0] mem_q [512];

    always_ff @(posedge clk_i) begin
        if (cpu_we_i) begin
            mem_q[cpu_addr_i] <= cpu_wdata_i;
        end
        // Issued last so it overrides a colliding CPU write.
        if (host_we_i) begin
            mem_q[host_addr_i] <= host_wdata_i;
        end
        host_rdata_o <= mem_q[host_addr_i];
    end

    assign cpu_rdata_o = mem_q[cpu_addr_i];

endmodule

// File: rtl/hdd_multi.sv
// hdd_multi: Apple II slot card exposing NUM_UNITS block devices to a host.
//   CLK_14M, RESET           - clock, synchronous active-high reset
//   PHASE_ZERO, IO_SELECT,
//   DEVICE_SELECT, RD, A,
//   D_IN, D_OUT              - CPU bus: $Cn00 ROM and $C0n0 register window
//   mounted, protect         - per-unit mounted / write-protect flags
//   blk_rd_req, blk_wr_req,
//   blk_unit, blk_lba,
//   blk_ack, blk_err         - host block request handshake
//   ram_addr/di/we, ram_do   - host port into the 512-byte sector buffer
// Optional: HDD_MULTI_TIMEOUT_EN aborts a host request after TIMEOUT_CYC cycles.
module hdd_multi
    import hdd_multi_pkg::*;
#(
    parameter int unsigned NUM_UNITS   = 2,
    parameter int unsigned SLOT        = 7,
    parameter int unsigned BLK_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic                 CLK_14M,
    input  logic                 RESET,
    input  logic                 PHASE_ZERO,
    input  logic                 IO_SELECT,
    input  logic                 DEVICE_SELECT,
    input  logic                 RD,
    input  logic [15:0]          A,
    input  logic [7:0]           D_IN,
    output logic [7:0]           D_OUT,
    input  logic [NUM_UNITS-1:0] mounted,
    input  logic [NUM_UNITS-1:0] protect,
    output logic                 blk_rd_req,
    output logic                 blk_wr_req,
    output logic [2:0]           blk_unit,
    output logic [BLK_W-1:0]     blk_lba,
    input  logic                 blk_ack,
    input  logic                 blk_err,
    input  logic [8:0]           ram_addr,
    input  logic [7:0]           ram_di,
    input  logic                 ram_we,
    output logic [7:0]           ram_do
);

    if (NUM_UNITS < 1 || NUM_UNITS > 8 || BLK_W < 16 || BLK_W > 24 || TIMEOUT_CYC < 1)
    begin : g_bad_params
        $error("hdd_multi: parameter out of range");
    end

    state_e state_q, state_d;

    logic             sel_d_q;
    logic [7:0]       cmd_q, unit_q, mem_lo_q, mem_hi_q, blk0_q, blk1_q, blk2_q;
    logic [7:0]       err_q;
    logic [7:0]       exec_res_q;
    logic             data_acc_q;
    logic [8:0]       ptr_q;
    logic [2:0]       req_unit_q;
    logic [BLK_W-1:0] req_lba_q;

    logic [3:0]       off;
    logic             acc_ev, sel_fall, busy, exec_ev, start_rd, start_wr, tmo_hit;
    logic [2:0]       unit_idx;
    logic             unit_ok;
    logic [7:0]       exec_code;
    logic [7:0]       mounted_pad, protect_pad;
    logic [BLK_W-1:0] lba_full;
    logic             cpu_we;
    logic [7:0]       cpu_rdata;
    logic             unused_a_hi;

    assign unused_a_hi = ^A[15:8];

    assign off      = A[3:0];
    assign acc_ev   = PHASE_ZERO & DEVICE_SELECT & ~sel_d_q;
    assign sel_fall = PHASE_ZERO & sel_d_q & ~DEVICE_SELECT;
    assign busy     = (state_q != StIdle);

    assign mounted_pad = 8'(mounted);
    assign protect_pad = 8'(protect);

    // Unit byte layout: DSSS 00UU -> index {UU, D}.
    assign unit_idx = {unit_q[1:0], unit_q[7]};
    assign unit_ok  = (unit_q[6:4] == 3'(SLOT)) && (unit_q[3:2] == 2'b00) &&
                      ({1'b0, unit_idx} < 4'(NUM_UNITS)) && mounted_pad[unit_idx];

    always_comb begin
        exec_code = ErrNone;
        if (!unit_ok) begin
            exec_code = ErrNoDev;
        end else begin
            case (cmd_q)
                CmdStatus, CmdRead, CmdFormat: exec_code = ErrNone;
                CmdWrite: exec_code = protect_pad[unit_idx] ? ErrWrProt : ErrNone;
                default:  exec_code = ErrBadCmd;
            endcase
        end
    end

    assign exec_ev  = acc_ev & RD & (off == RegExec) & ~busy;
    assign start_rd = exec_ev & (exec_code == ErrNone) & (cmd_q == CmdRead);
    assign start_wr = exec_ev & (exec_code == ErrNone) & (cmd_q == CmdWrite);

    if (BLK_W > 16) begin : g_lba3
        assign lba_full = {blk2_q[BLK_W-17:0], blk1_q, blk0_q};
    end else begin : g_lba2
        assign lba_full = {blk1_q, blk0_q};
    end

`ifdef HDD_MULTI_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    logic [TmoW-1:0] tmo_cnt_q;

    always_ff @(posedge CLK_14M) begin
        if (RESET || !busy) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = busy && (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_rd) begin
                    state_d = StRdReq;
                end else if (start_wr) begin
                    state_d = StWrReq;
                end
            end
            StRdReq, StWrReq: begin
                if (blk_ack || tmo_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK_14M) begin
        if (RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK_14M) begin
        if (RESET) begin
            sel_d_q    <= 1'b0;
            cmd_q      <= '0;
            unit_q     <= '0;
            mem_lo_q   <= '0;
            mem_hi_q   <= '0;
            blk0_q     <= '0;
            blk1_q     <= '0;
            blk2_q     <= '0;
            err_q      <= ErrNone;
            exec_res_q <= '0;
            data_acc_q <= 1'b0;
            ptr_q      <= '0;
            req_unit_q <= '0;
            req_lba_q  <= '0;
        end else begin
            if (PHASE_ZERO) begin
                sel_d_q <= DEVICE_SELECT;
            end

            if (acc_ev && !RD) begin
                case (off)
                    RegCmd:   cmd_q    <= D_IN;
                    RegUnit:  unit_q   <= D_IN;
                    RegMemLo: mem_lo_q <= D_IN;
                    RegMemHi: mem_hi_q <= D_IN;
                    RegBlk0:  blk0_q   <= D_IN;
                    RegBlk1:  blk1_q   <= D_IN;
                    RegBlk2:  blk2_q   <= D_IN;
                    default:  ;
                endcase
            end

            // Held so offset-0 reads stay stable for the rest of the select window.
            if (acc_ev && RD && (off == RegExec)) begin
                exec_res_q <= busy ? StatBusy : exec_code;
            end

            if (start_rd || start_wr) begin
                req_unit_q <= unit_idx;
                req_lba_q  <= lba_full;
            end

            if (exec_ev) begin
                err_q <= exec_code;
            end else if (busy && blk_ack) begin
                err_q <= blk_err ? ErrIo : ErrNone;
            end else if (tmo_hit) begin
                err_q <= ErrIo;
            end

            // A data access taken while idle arms the post-increment at deselect.
            if (acc_ev && (off == RegData)) begin
                data_acc_q <= ~busy;
            end else if (sel_fall) begin
                data_acc_q <= 1'b0;
            end

            if (exec_ev || (acc_ev && !RD && (off == RegCmd))) begin
                ptr_q <= '0;
            end else if (sel_fall && data_acc_q) begin
                ptr_q <= ptr_q + 9'd1;
            end
        end
    end

    assign cpu_we = acc_ev & ~RD & (off == RegData) & ~busy;

    hdd_sector_ram u_ram (
        .clk_i        (CLK_14M),
        .cpu_addr_i   (ptr_q),
        .cpu_we_i     (cpu_we),
        .cpu_wdata_i  (D_IN),
        .cpu_rdata_o  (cpu_rdata),
        .host_addr_i  (ram_addr),
        .host_we_i    (ram_we),
        .host_wdata_i (ram_di),
        .host_rdata_o (ram_do)
    );

    always_comb begin
        D_OUT = 8'hFF;
        if (!RESET && PHASE_ZERO && RD) begin
            if (IO_SELECT) begin
                D_OUT = rom_byte(A[7:0]);
            end else if (DEVICE_SELECT) begin
                case (off)
                    RegExec:   D_OUT = acc_ev ? (busy ? StatBusy : exec_code) : exec_res_q;
                    RegStatus: D_OUT = {busy, 6'b0, (err_q != ErrNone)};
                    RegCmd:    D_OUT = cmd_q;
                    RegUnit:   D_OUT = unit_q;
                    RegMemLo:  D_OUT = mem_lo_q;
                    RegMemHi:  D_OUT = mem_hi_q;
                    RegBlk0:   D_OUT = blk0_q;
                    RegBlk1:   D_OUT = blk1_q;
                    RegBlk2:   D_OUT = blk2_q;
                    RegData:   D_OUT = (acc_ev ? ~busy : data_acc_q) ? cpu_rdata : 8'hFF;
                    RegErr:    D_OUT = err_q;
                    default:   D_OUT = 8'hFF;
                endcase
            end
        end
    end

    assign blk_rd_req = (state_q == StRdReq);
    assign blk_wr_req = (state_q == StWrReq);
    assign blk_unit   = req_unit_q;
    assign blk_lba    = req_lba_q;

endmodule

// File: tb/tb_hdd_multi.sv
// tb_hdd_multi: directed, table-driven bench for hdd_multi (2 units, slot 7).
module tb_hdd_multi;

    logic        CLK_14M = 1'b0;
    logic        RESET = 1'b1;
    logic        PHASE_ZERO = 1'b0;
    logic        IO_SELECT = 1'b0;
    logic        DEVICE_SELECT = 1'b0;
    logic        RD = 1'b0;
    logic [15:0] A = 16'h0000;
    logic [7:0]  D_IN = 8'h00;
    logic [7:0]  D_OUT;
    logic [1:0]  mounted = 2'b11;
    logic [1:0]  protect = 2'b10;
    logic        blk_rd_req, blk_wr_req;
    logic [2:0]  blk_unit;
    logic [15:0] blk_lba;
    logic        blk_ack = 1'b0;
    logic        blk_err = 1'b0;
    logic [8:0]  ram_addr = 9'd0;
    logic [7:0]  ram_di = 8'h00;
    logic        ram_we = 1'b0;
    logic [7:0]  ram_do;

    int n_pass = 0;
    int n_total = 0;

    always #5 CLK_14M = ~CLK_14M;

    hdd_multi #(
        .NUM_UNITS   (2),
        .SLOT        (7),
        .BLK_W       (16),
        .TIMEOUT_CYC (100)
    ) dut (
        .CLK_14M       (CLK_14M),
        .RESET         (RESET),
        .PHASE_ZERO    (PHASE_ZERO),
        .IO_SELECT     (IO_SELECT),
        .DEVICE_SELECT (DEVICE_SELECT),
        .RD            (RD),
        .A             (A),
        .D_IN          (D_IN),
        .D_OUT         (D_OUT),
        .mounted       (mounted),
        .protect       (protect),
        .blk_rd_req    (blk_rd_req),
        .blk_wr_req    (blk_wr_req),
        .blk_unit      (blk_unit),
        .blk_lba       (blk_lba),
        .blk_ack       (blk_ack),
        .blk_err       (blk_err),
        .ram_addr      (ram_addr),
        .ram_di        (ram_di),
        .ram_we        (ram_we),
        .ram_do        (ram_do)
    );

    typedef struct {
        logic [7:0] unit;
        logic [7:0] cmd;
        logic [1:0] mnt;
        logic [7:0] exp_exec;
        logic [7:0] exp_stat;
        logic [7:0] exp_err;
        logic       exp_rd;
        logic       exp_wr;
        logic [2:0] exp_unit;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // One $C0Fx bus cycle; D_OUT is sampled one clock after the access edge.
    task automatic bus(input logic [3:0] off, input logic rd, input logic [7:0] wd,
                       output logic [7:0] q);
        @(negedge CLK_14M);
        A = 16'hC0F0 | {12'h000, off};
        D_IN = wd;
        RD = rd;
        PHASE_ZERO = 1'b1;
        DEVICE_SELECT = 1'b1;
        @(negedge CLK_14M);
        q = D_OUT;
        @(negedge CLK_14M);
        DEVICE_SELECT = 1'b0;
        RD = 1'b0;
        @(negedge CLK_14M);
        PHASE_ZERO = 1'b0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [7:0] d);
        logic [7:0] dummy;
        bus(off, 1'b0, d, dummy);
    endtask

    task automatic rd(input logic [3:0] off, output logic [7:0] q);
        bus(off, 1'b1, 8'h00, q);
    endtask

    task automatic host_wr(input logic [8:0] a, input logic [7:0] d);
        @(negedge CLK_14M);
        ram_addr = a;
        ram_di = d;
        ram_we = 1'b1;
        @(negedge CLK_14M);
        ram_we = 1'b0;
    endtask

    task automatic host_rd(input logic [8:0] a, output logic [7:0] q);
        @(negedge CLK_14M);
        ram_addr = a;
        @(negedge CLK_14M);
        q = ram_do;
    endtask

    task automatic ack(input logic e);
        @(negedge CLK_14M);
        blk_ack = 1'b1;
        blk_err = e;
        @(negedge CLK_14M);
        blk_ack = 1'b0;
        blk_err = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int cnt;

        //           unit   cmd    mnt    exec   stat   err    rd    wr    unit
        vecs[0] = '{8'h70, 8'h00, 2'b11, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0};
        vecs[1] = '{8'hF0, 8'h02, 2'b11, 8'h2B, 8'h01, 8'h2B, 1'b0, 1'b0, 3'd0};
        vecs[2] = '{8'h71, 8'h00, 2'b11, 8'h28, 8'h01, 8'h28, 1'b0, 1'b0, 3'd0};
        vecs[3] = '{8'h60, 8'h01, 2'b11, 8'h28, 8'h01, 8'h28, 1'b0, 1'b0, 3'd0};
        vecs[4] = '{8'h70, 8'h05, 2'b11, 8'h01, 8'h01, 8'h01, 1'b0, 1'b0, 3'd0};
        vecs[5] = '{8'h70, 8'h00, 2'b10, 8'h28, 8'h01, 8'h28, 1'b0, 1'b0, 3'd0};
        vecs[6] = '{8'h74, 8'h00, 2'b11, 8'h28, 8'h01, 8'h28, 1'b0, 1'b0, 3'd0};
        vecs[7] = '{8'h70, 8'h00, 2'b11, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0};
        vecs[8] = '{8'h70, 8'h02, 2'b11, 8'h00, 8'h80, 8'h00, 1'b0, 1'b1, 3'd0};
        vecs[9] = '{8'hF0, 8'h01, 2'b11, 8'h00, 8'h80, 8'h00, 1'b1, 1'b0, 3'd1};

        repeat (3) @(negedge CLK_14M);
        check("reset dout", D_OUT, 8'hFF);
        check("reset rd_req", blk_rd_req, 1'b0);
        check("reset wr_req", blk_wr_req, 1'b0);
        RESET = 1'b0;
        rd(4'h1, d); check("reset status", d, 8'h00);
        rd(4'h9, d); check("reset err", d, 8'h00);
        check("idle dout", D_OUT, 8'hFF);

        wr(4'h6, 8'h12);
        wr(4'h7, 8'h00);

        for (int i = 0; i < NV; i++) begin
            mounted = vecs[i].mnt;
            wr(4'h3, vecs[i].unit);
            wr(4'h2, vecs[i].cmd);
            rd(4'h0, d);
            check($sformatf("v%0d exec", i), d, vecs[i].exp_exec);
            check($sformatf("v%0d rd_req", i), blk_rd_req, vecs[i].exp_rd);
            check($sformatf("v%0d wr_req", i), blk_wr_req, vecs[i].exp_wr);
            rd(4'h1, d);
            check($sformatf("v%0d status", i), d, vecs[i].exp_stat);
            rd(4'h9, d);
            check($sformatf("v%0d err", i), d, vecs[i].exp_err);
            if (vecs[i].exp_rd || vecs[i].exp_wr) begin
                check($sformatf("v%0d blk_unit", i), blk_unit, vecs[i].exp_unit);
                check($sformatf("v%0d blk_lba", i), blk_lba, 16'h0012);
                ack(1'b0);
                rd(4'h1, d);
                check($sformatf("v%0d status after ack", i), d, 8'h00);
            end
        end
        mounted = 2'b11;

        // READ block 0x0012, busy behaviour, then stream host data.
        wr(4'h3, 8'h70);
        wr(4'h2, 8'h01);
        rd(4'h0, d); check("rd exec", d, 8'h00);
        check("rd req high", blk_rd_req, 1'b1);
        check("rd lba", blk_lba, 16'h0012);
        rd(4'h1, d); check("rd status busy", d, 8'h80);
        rd(4'h0, d); check("exec while busy", d, 8'h80);
        rd(4'h8, d); check("data while busy", d, 8'hFF);
        check("rd req held", blk_rd_req, 1'b1);
        for (int k = 0; k < 4; k++) host_wr(9'(k), 8'hA0 + 8'(k));
        ack(1'b0);
        check("rd req dropped", blk_rd_req, 1'b0);
        rd(4'h1, d); check("rd status done", d, 8'h00);
        for (int k = 0; k < 4; k++) begin
            rd(4'h8, d);
            check($sformatf("stream %0d", k), d, 8'hA0 + 8'(k));
        end

        // Host error completion.
        wr(4'h6, 8'h34);
        wr(4'h7, 8'h12);
        rd(4'h0, d); check("err exec", d, 8'h00);
        check("err lba", blk_lba, 16'h1234);
        ack(1'b1);
        rd(4'h9, d); check("io err code", d, 8'h27);
        rd(4'h1, d); check("io err status", d, 8'h01);

        // Reset mid-request; a late ack must be ignored.
        rd(4'h0, d); check("pre-reset exec", d, 8'h00);
        check("pre-reset rd_req", blk_rd_req, 1'b1);
        @(negedge CLK_14M);
        RESET = 1'b1;
        @(negedge CLK_14M);
        check("reset drops rd_req", blk_rd_req, 1'b0);
        check("reset dout ff", D_OUT, 8'hFF);
        RESET = 1'b0;
        ack(1'b1);
        check("late ack no req", blk_rd_req, 1'b0);
        rd(4'h1, d); check("late ack status", d, 8'h00);
        rd(4'h9, d); check("late ack err", d, 8'h00);
        rd(4'h2, d); check("reset cmd", d, 8'h00);
        rd(4'h3, d); check("reset unit", d, 8'h00);
        host_rd(9'd0, d); check("buffer kept", d, 8'hA0);

        // Same-address CPU/host write collision: host wins.
        wr(4'h2, 8'h00);
        @(negedge CLK_14M);
        A = 16'hC0F8;
        D_IN = 8'h11;
        RD = 1'b0;
        PHASE_ZERO = 1'b1;
        DEVICE_SELECT = 1'b1;
        ram_addr = 9'd0;
        ram_di = 8'h22;
        ram_we = 1'b1;
        @(negedge CLK_14M);
        ram_we = 1'b0;
        @(negedge CLK_14M);
        DEVICE_SELECT = 1'b0;
        @(negedge CLK_14M);
        PHASE_ZERO = 1'b0;
        host_rd(9'd0, d); check("collision host wins", d, 8'h22);

        // 513 sequential writes wrap the pointer onto byte 0.
        wr(4'h2, 8'h00);
        for (int i = 0; i < 513; i++) wr(4'h8, (i == 512) ? 8'hC3 : 8'(i));
        host_rd(9'd0, d);   check("wrap host 0", d, 8'hC3);
        host_rd(9'd1, d);   check("wrap host 1", d, 8'h01);
        host_rd(9'd511, d); check("wrap host 511", d, 8'hFF);
        wr(4'h2, 8'h00);
        rd(4'h8, d); check("cpu read 0", d, 8'hC3);
        rd(4'h8, d); check("cpu read 1", d, 8'h01);

        // Firmware ROM.
        @(negedge CLK_14M);
        A = 16'hC701; IO_SELECT = 1'b1; PHASE_ZERO = 1'b1; RD = 1'b1;
        #2 check("rom 01", D_OUT, 8'h20);
        A = 16'hC705;
        #2 check("rom 05", D_OUT, 8'h03);
        A = 16'hC7FF;
        #2 check("rom ff", D_OUT, 8'h0A);
        PHASE_ZERO = 1'b0;
        #2 check("rom no phase", D_OUT, 8'hFF);
        IO_SELECT = 1'b0; RD = 1'b0;

        // Request with no ack: timeout build aborts, default build waits.
        wr(4'h3, 8'h70);
        wr(4'h2, 8'h01);
        @(negedge CLK_14M);
        A = 16'hC0F0; RD = 1'b1; PHASE_ZERO = 1'b1; DEVICE_SELECT = 1'b1;
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK_14M);
            if (k == 1) begin DEVICE_SELECT = 1'b0; RD = 1'b0; end
            if (k == 2) PHASE_ZERO = 1'b0;
            if (blk_rd_req) cnt++;
            else if (cnt > 0) break;
        end
`ifdef HDD_MULTI_TIMEOUT_EN
        check("timeout cycles", cnt, 100);
        rd(4'h9, d); check("timeout err", d, 8'h27);
        rd(4'h1, d); check("timeout status", d, 8'h01);
`else
        check("no timeout wait", cnt, 300);
        ack(1'b0);
        check("wait released", blk_rd_req, 1'b0);
        rd(4'h1, d); check("wait status", d, 8'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
